// File: rtl/sal_arb_out_fifo_if.sv
// Handshake bundle between the round-robin arbiter, the output FIFO and its consumer.
// The slave modport is the FIFO's view; the master modport drives it.
interface sal_arb_out_fifo_if #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 4
);
    logic                     req_i;
    logic [DATA_WIDTH-1:0]    data_i;
    logic                     gnt_o;
    logic                     valid_o;
    logic [DATA_WIDTH-1:0]    data_o;
    logic                     ready_i;
    logic [$clog2(DEPTH):0]   cnt_o;
    logic                     af_o;
    logic                     ovf_o;

    modport slave (
        input  req_i, data_i, ready_i,
        output gnt_o, valid_o, data_o, cnt_o, af_o, ovf_o
    );

    modport master (
        output req_i, data_i, ready_i,
        input  gnt_o, valid_o, data_o, cnt_o, af_o, ovf_o
    );
endinterface

// File: rtl/sal_arb_out_fifo.sv
// First-word-fall-through buffer behind the 64-to-1 arbiter; gnt_o means "space available".
// Every output is decoded from registered state only, so the arbiter sees no path from ready_i.
module sal_arb_out_fifo #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 4,
    parameter int AF_THRESH  = 3
) (
    input logic               clk,
    input logic               rst_n,
    sal_arb_out_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  ovf;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // rst_n is active-high here; every output is forced quiet while it is asserted.
    assign bus.gnt_o   = !rst_n && !full;
    assign bus.valid_o = !rst_n && !empty;
    assign bus.data_o  = rst_n ? '0 : mem[rd_ptr];
    assign bus.cnt_o   = count;
    assign bus.af_o    = (count >= CW'(AF_THRESH));
    assign bus.ovf_o   = ovf;

    assign push = bus.req_i && bus.gnt_o;
    assign pop  = bus.valid_o && bus.ready_i;

    // NOTE: reset is asynchronous and active-high, so it sits in the sensitivity list on posedge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Guard only: gnt_o already blocks pushes when full, so this must never fire.
            if (bus.req_i && bus.gnt_o && full) ovf <= 1'b1;
        end
    end

    // NOTE: storage is deliberately left out of reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.data_i;
    end
endmodule

// File: tb/tb_sal_arb_out_fifo.sv
// Randomised and directed bench for sal_arb_out_fifo against a queue-based reference model.
module tb_sal_arb_out_fifo;
    localparam int DW    = 12;
    localparam int DEPTH = 4;
    localparam int AFT   = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sal_arb_out_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    sal_arb_out_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AFT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] popped_log[$];
    logic          last_push;
    logic          last_pop;
    int            max_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs to the model, then advance the model.
    task automatic step(input logic req, input logic [DW-1:0] d, input logic ready);
        logic exp_gnt;
        logic exp_valid;
        bus.req_i   = req;
        bus.data_i  = d;
        bus.ready_i = ready;
        #1;
        exp_gnt   = (model_q.size() != DEPTH);
        exp_valid = (model_q.size() != 0);
        check("gnt",   32'(bus.gnt_o),   32'(exp_gnt));
        check("valid", 32'(bus.valid_o), 32'(exp_valid));
        check("cnt",   32'(bus.cnt_o),   32'(model_q.size()));
        check("af",    32'(bus.af_o),    32'(model_q.size() >= AFT));
        check("ovf",   32'(bus.ovf_o),   32'd0);
        if (exp_valid) check("data", 32'(bus.data_o), 32'(model_q[0]));
        if (int'(bus.cnt_o) > max_cnt) max_cnt = int'(bus.cnt_o);
        last_push = req && exp_gnt;
        last_pop  = ready && exp_valid;
        @(posedge clk);
        if (last_pop)  popped_log.push_back(model_q.pop_front());
        if (last_push) model_q.push_back(d);
        @(negedge clk);
    endtask

    initial begin
        int np;
        int budget;
        rst_n       = 1'b1;
        bus.req_i   = 1'b0;
        bus.data_i  = '0;
        bus.ready_i = 1'b0;
        max_cnt     = 0;

        // Outputs while reset is held.
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt",   32'(bus.gnt_o),   32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_cnt",   32'(bus.cnt_o),   32'd0);
        check("rst_af",    32'(bus.af_o),    32'd0);
        check("rst_data",  32'(bus.data_o),  32'd0);
        check("rst_ovf",   32'(bus.ovf_o),   32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        step(1'b0, '0, 1'b0);

        // Fill to full with the consumer stalled; 0x009 is held while full.
        popped_log.delete();
        for (int i = 5; i <= 8; i++) step(1'b1, DW'(i), 1'b0);
        check("full_cnt", 32'(bus.cnt_o), 32'd4);
        check("full_gnt", 32'(bus.gnt_o), 32'd0);
        step(1'b1, DW'(9), 1'b0);
        check("held_not_taken", 32'(last_push), 32'd0);
        check("pop_head", 32'(bus.data_o), 32'h005);
        step(1'b1, DW'(9), 1'b1);
        check("pop_from_full", 32'(last_pop), 32'd1);
        check("gnt_after_pop", 32'(bus.gnt_o), 32'd1);
        step(1'b1, DW'(9), 1'b0);
        check("refill_cnt", 32'(bus.cnt_o), 32'd4);
        repeat (4) step(1'b0, '0, 1'b1);
        check("drain_len", 32'(popped_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < popped_log.size(); i++)
            check("drain_order", 32'(popped_log[i]), 32'(5 + i));

        // Steady stream: one push and one pop per cycle.
        popped_log.delete();
        for (int i = 0; i < 64; i++) step(1'b1, DW'(i), 1'b1);
        step(1'b0, '0, 1'b1);
        check("stream_len", 32'(popped_log.size()), 32'd64);
        for (int i = 0; i < 64 && i < popped_log.size(); i++)
            if (popped_log[i] !== DW'(i)) check("stream_order", 32'(popped_log[i]), 32'(i));
        check("stream_empty", 32'(bus.cnt_o), 32'd0);

        // Pointer wrap with a 50% random consumer.
        popped_log.delete();
        max_cnt = 0;
        np      = 0;
        budget  = 0;
        while (popped_log.size() < 10 && budget < 200) begin
            step(np < 10, DW'(np), 1'($urandom_range(0, 1)));
            if (last_push) np++;
            budget++;
        end
        check("wrap_len", 32'(popped_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < popped_log.size(); i++)
            check("wrap_order", 32'(popped_log[i]), 32'(i));
        check("wrap_max_cnt_ok", 32'(max_cnt <= DEPTH), 32'd1);

        // Asynchronous reset with three entries queued.
        for (int i = 0; i < 3; i++) step(1'b1, DW'(12'h0F0 + i), 1'b0);
        check("pre_rst_cnt", 32'(bus.cnt_o), 32'd3);
        bus.req_i = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        check("async_valid", 32'(bus.valid_o), 32'd0);
        check("async_cnt",   32'(bus.cnt_o),   32'd0);
        check("async_gnt",   32'(bus.gnt_o),   32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        model_q.delete();
        popped_log.delete();
        step(1'b1, DW'(12'h0AA), 1'b0);
        check("post_rst_push", 32'(last_push), 32'd1);
        check("post_rst_head", 32'(bus.data_o), 32'h0AA);
        step(1'b0, '0, 1'b1);
        check("post_rst_first_out", 32'(popped_log.size() == 1 && popped_log[0] == DW'(12'h0AA)), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sal_arb_out_fifo.md
Name: sal_arb_out_fifo

Overview:
- Output buffer placed directly downstream of the 64-to-1 round-robin arbiter.
- Consumes the arbiter's winning request (req/data) and returns its gnt as "space available".
- Holds granted words in a first-word-fall-through FIFO, so a stalled consumer never stalls arbitration until the buffer is full.
- Reports occupancy and almost-full to upstream flow control.

Parameters:
- DATA_WIDTH, 12, width of the arbiter payload word.
- DEPTH, 4, number of FIFO entries; power of 2, DEPTH >= 2.
- AF_THRESH, 3, occupancy at or above which af_o asserts; 1 <= AF_THRESH <= DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-high.
- req_i  input  1  arbiter has a valid winner (arbiter req_o).
- data_i  input  DATA_WIDTH  winner payload (arbiter data_o).
- gnt_o  output  1  accept strobe to arbiter (arbiter gnt_i).
- valid_o  output  1  head entry valid.
- data_o  output  DATA_WIDTH  head entry payload (FWFT).
- ready_i  input  1  consumer accepts head this cycle.
- cnt_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- af_o  output  1  almost full, cnt_o >= AF_THRESH.
- ovf_o  output  1  sticky: req_i && gnt_o ever sampled with FIFO full (design-error flag; must stay 0).

Behaviour:
- Reset (rst_n high, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; ovf_o goes to 0.
  - Storage is not reset.
  - Outputs while in reset: valid_o=0, gnt_o=0, cnt_o=0, af_o=0, data_o=0.
- Reset mid-operation: all queued entries are discarded immediately. The first cycle after release shows gnt_o=1 and valid_o=0.
- gnt_o = !rst_n_active && (count != DEPTH). Decoded from registered count only; there is no combinational path from req_i or ready_i.
- Push: req_i && gnt_o at a clock edge. data_i is written at wr_ptr, wr_ptr increments modulo DEPTH.
- Pop: valid_o && ready_i at a clock edge. rd_ptr increments modulo DEPTH.
- valid_o = (count != 0); data_o = mem[rd_ptr]. data_o is don't-care but stable when valid_o=0.
- Latency: a word pushed at edge N appears on valid_o/data_o after edge N (1 cycle). There is no same-cycle bypass when empty.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; both pointers advance.
- Full (count==DEPTH):
  - gnt_o=0, so no push. The arbiter must hold req_i/data_i, which its protocol guarantees.
  - A pop in this cycle frees a slot, and gnt_o=1 from the next cycle.
- Empty (count==0):
  - valid_o=0, so ready_i is ignored.
  - A push in this cycle makes valid_o=1 next cycle.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is decided from count, never from pointer compare.
- af_o and cnt_o are registered-equivalent, derived from count with no input-path logic.
- ovf_o is set if a push is attempted while count==DEPTH. Unreachable by construction; it is an assertion-style guard for verification, cleared only by reset.
- Ordering: strict FIFO. Output order equals grant order.

Test Plan:
- Reset release, req_i=0 -> gnt_o=1, valid_o=0, cnt_o=0, af_o=0, ovf_o=0.
- ready_i=0; req_i=1 with data 0x005, 0x006, 0x007, 0x008 on consecutive cycles:
  - cnt_o steps 1,2,3,4.
  - af_o rises at cnt=3.
  - gnt_o=0 at cnt=4; a held 0x009 is not accepted.
- From full, ready_i=1 for 1 cycle -> data_o=0x005 popped. Next cycle gnt_o=1 and 0x009 is pushed; cnt_o stays 4. Drain order is 0x006, 0x007, 0x008, 0x009.
- Steady stream: req_i=1 and ready_i=1 every cycle, data 0..63 -> cnt_o toggles 0/1 then holds 1. Output matches input with 1-cycle latency; all 64 IDs appear in order; ovf_o=0.
- Wrap: push/pop 10 words with ready_i random 50% -> output order 0..9, no loss or duplicate, cnt_o never exceeds 4.
- Assert rst_n with 3 entries queued -> in the same cycle (async) valid_o=0, cnt_o=0. After release gnt_o=1, and the next pushed word 0x0AA is the first word out.
